// File: rtl/ebr_dp_model.sv
// Behavioural model of a true dual-port embedded block RAM with per-port
// write modes, chip-select decode, optional output register and output resets.
module ebr_dp_model #(
    parameter int          DATA_WIDTH  = 18,
    parameter int          ADDR_WIDTH  = 10,
    parameter string       REGMODE_A   = "NOREG",
    parameter string       REGMODE_B   = "NOREG",
    parameter string       WRITEMODE_A = "NORMAL",
    parameter string       WRITEMODE_B = "NORMAL",
    parameter logic [2:0]  CSDECODE_A  = 3'b000,
    parameter logic [2:0]  CSDECODE_B  = 3'b000
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CEA,
    input  logic                  OCEA,
    input  logic                  WEA,
    input  logic [2:0]            CSA,
    input  logic                  RSTA,
    input  logic [ADDR_WIDTH-1:0] ADA,
    input  logic [DATA_WIDTH-1:0] DIA,
    output logic [DATA_WIDTH-1:0] DOA,
    input  logic                  CEB,
    input  logic                  OCEB,
    input  logic                  WEB,
    input  logic [2:0]            CSB,
    input  logic                  RSTB,
    input  logic [ADDR_WIDTH-1:0] ADB,
    input  logic [DATA_WIDTH-1:0] DIB,
    output logic [DATA_WIDTH-1:0] DOB
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] WM_NORMAL = 2'd0;
    localparam logic [1:0] WM_WT     = 2'd1;
    localparam logic [1:0] WM_RBW    = 2'd2;

    localparam logic [1:0] WM_A = (WRITEMODE_A == "WRITETHROUGH")    ? WM_WT  :
                                  (WRITEMODE_A == "READBEFOREWRITE") ? WM_RBW : WM_NORMAL;
    localparam logic [1:0] WM_B = (WRITEMODE_B == "WRITETHROUGH")    ? WM_WT  :
                                  (WRITEMODE_B == "READBEFOREWRITE") ? WM_RBW : WM_NORMAL;

    // Reject unsupported configurations at elaboration time.
    if (REGMODE_A != "NOREG" && REGMODE_A != "OUTREG") begin : g_bad_regmode_a
        $error("ebr_dp_model: illegal REGMODE_A");
    end
    if (REGMODE_B != "NOREG" && REGMODE_B != "OUTREG") begin : g_bad_regmode_b
        $error("ebr_dp_model: illegal REGMODE_B");
    end
    if (WRITEMODE_A != "NORMAL" && WRITEMODE_A != "WRITETHROUGH" &&
        WRITEMODE_A != "READBEFOREWRITE") begin : g_bad_writemode_a
        $error("ebr_dp_model: illegal WRITEMODE_A");
    end
    if (WRITEMODE_B != "NORMAL" && WRITEMODE_B != "WRITETHROUGH" &&
        WRITEMODE_B != "READBEFOREWRITE") begin : g_bad_writemode_b
        $error("ebr_dp_model: illegal WRITEMODE_B");
    end
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_width
        $error("ebr_dp_model: DATA_WIDTH and ADDR_WIDTH must be positive");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_lat_a;
    logic [DATA_WIDTH-1:0] r_lat_b;
    logic                  w_en_a;
    logic                  w_en_b;

    assign w_en_a = CEA && (CSA == CSDECODE_A);
    assign w_en_b = CEB && (CSB == CSDECODE_B);

    // Port B is written last so it wins a same-address collision; RSTN never touches the array.
    always_ff @(posedge CLK) begin
        if (w_en_a && WEA) begin
            r_mem[ADA] <= DIA;
        end
        if (w_en_b && WEB) begin
            r_mem[ADB] <= DIB;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_lat_a <= '0;
        end else if (RSTA) begin
            r_lat_a <= '0;
        end else if (w_en_a) begin
            if (!WEA || WM_A == WM_RBW) begin
                r_lat_a <= r_mem[ADA];
            end else if (WM_A == WM_WT) begin
                r_lat_a <= DIA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_lat_b <= '0;
        end else if (RSTB) begin
            r_lat_b <= '0;
        end else if (w_en_b) begin
            if (!WEB || WM_B == WM_RBW) begin
                r_lat_b <= r_mem[ADB];
            end else if (WM_B == WM_WT) begin
                r_lat_b <= DIB;
            end
        end
    end

    // The output register is clocked by OCEx alone, not by the port enable.
    if (REGMODE_A == "OUTREG") begin : g_outreg_a
        logic [DATA_WIDTH-1:0] r_oreg_a;
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_oreg_a <= '0;
            end else if (RSTA) begin
                r_oreg_a <= '0;
            end else if (OCEA) begin
                r_oreg_a <= r_lat_a;
            end
        end
        assign DOA = r_oreg_a;
    end else begin : g_noreg_a
        logic w_unused_oce_a;
        assign w_unused_oce_a = OCEA;
        assign DOA = r_lat_a;
    end

    if (REGMODE_B == "OUTREG") begin : g_outreg_b
        logic [DATA_WIDTH-1:0] r_oreg_b;
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_oreg_b <= '0;
            end else if (RSTB) begin
                r_oreg_b <= '0;
            end else if (OCEB) begin
                r_oreg_b <= r_lat_b;
            end
        end
        assign DOB = r_oreg_b;
    end else begin : g_noreg_b
        logic w_unused_oce_b;
        assign w_unused_oce_b = OCEB;
        assign DOB = r_lat_b;
    end

endmodule

// File: tb/tb_ebr_dp_model.sv
// Bench for ebr_dp_model: three instances with different modes share one
// stimulus stream; a reference model feeds a scoreboard queue read by a monitor.
module tb_ebr_dp_model;

  localparam int DW   = 18;
  localparam int AW   = 10;
  localparam int NI   = 3;
  localparam int SB_W = NI * 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic          ce [2];
  logic          oce [2];
  logic          we [2];
  logic          rst [2];
  logic [2:0]    cs [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] di [2];

  logic [DW-1:0] doa0, dob0, doa1, dob1, doa2, dob2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SB_W-1:0] exp_q[$];

  // d0: A OUTREG/NORMAL, B NOREG/NORMAL
  ebr_dp_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .REGMODE_A("OUTREG"), .REGMODE_B("NOREG"),
    .WRITEMODE_A("NORMAL"), .WRITEMODE_B("NORMAL"),
    .CSDECODE_A(3'b101), .CSDECODE_B(3'b000)) u_d0 (
    .CLK(clk), .RSTN(rstn),
    .CEA(ce[0]), .OCEA(oce[0]), .WEA(we[0]), .CSA(cs[0]), .RSTA(rst[0]), .ADA(ad[0]), .DIA(di[0]), .DOA(doa0),
    .CEB(ce[1]), .OCEB(oce[1]), .WEB(we[1]), .CSB(cs[1]), .RSTB(rst[1]), .ADB(ad[1]), .DIB(di[1]), .DOB(dob0));

  // d1: A NOREG/WRITETHROUGH, B OUTREG/READBEFOREWRITE
  ebr_dp_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .REGMODE_A("NOREG"), .REGMODE_B("OUTREG"),
    .WRITEMODE_A("WRITETHROUGH"), .WRITEMODE_B("READBEFOREWRITE"),
    .CSDECODE_A(3'b101), .CSDECODE_B(3'b000)) u_d1 (
    .CLK(clk), .RSTN(rstn),
    .CEA(ce[0]), .OCEA(oce[0]), .WEA(we[0]), .CSA(cs[0]), .RSTA(rst[0]), .ADA(ad[0]), .DIA(di[0]), .DOA(doa1),
    .CEB(ce[1]), .OCEB(oce[1]), .WEB(we[1]), .CSB(cs[1]), .RSTB(rst[1]), .ADB(ad[1]), .DIB(di[1]), .DOB(dob1));

  // d2: A NOREG/READBEFOREWRITE, B NOREG/WRITETHROUGH
  ebr_dp_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .REGMODE_A("NOREG"), .REGMODE_B("NOREG"),
    .WRITEMODE_A("READBEFOREWRITE"), .WRITEMODE_B("WRITETHROUGH"),
    .CSDECODE_A(3'b101), .CSDECODE_B(3'b000)) u_d2 (
    .CLK(clk), .RSTN(rstn),
    .CEA(ce[0]), .OCEA(oce[0]), .WEA(we[0]), .CSA(cs[0]), .RSTA(rst[0]), .ADA(ad[0]), .DIA(di[0]), .DOA(doa2),
    .CEB(ce[1]), .OCEB(oce[1]), .WEB(we[1]), .CSB(cs[1]), .RSTB(rst[1]), .ADB(ad[1]), .DIB(di[1]), .DOB(dob2));

  // ---------------- configuration table ----------------
  // write mode codes: 0 = NORMAL, 1 = WRITETHROUGH, 2 = READBEFOREWRITE
  int wm_tab [NI][2] = '{'{0, 0}, '{1, 2}, '{2, 1}};

  function automatic bit is_outreg(int i, int p);
    return (i == 0 && p == 0) || (i == 1 && p == 1);
  endfunction

  function automatic logic [2:0] csd(int p);
    return (p == 0) ? 3'b101 : 3'b000;
  endfunction

  function automatic logic [DW-1:0] dut_do(int i, int p);
    case (i * 2 + p)
      0: return doa0;
      1: return dob0;
      2: return doa1;
      3: return dob1;
      4: return doa2;
      default: return dob2;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem  [NI][1 << AW];
  logic [DW-1:0] m_lat  [NI][2];
  logic [DW-1:0] m_oreg [NI][2];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        m_lat[i][p]  = '0;
        m_oreg[i][p] = '0;
      end
    end
  endtask

  // One clock edge: every port reads the array as it stood before the edge,
  // then A writes, then B writes (B wins a same-address collision).
  task automatic model_step();
    logic            en [2];
    logic [DW-1:0]   rd;
    logic [DW-1:0]   nl;
    logic [SB_W-1:0] e;
    for (int p = 0; p < 2; p++) en[p] = ce[p] && (cs[p] == csd(p));
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        rd = m_mem[i][ad[p]];
        nl = m_lat[i][p];
        if (rst[p]) nl = '0;
        else if (en[p]) begin
          if (!we[p]) nl = rd;
          else if (wm_tab[i][p] == 1) nl = di[p];
          else if (wm_tab[i][p] == 2) nl = rd;
        end
        if (rst[p]) m_oreg[i][p] = '0;
        else if (oce[p]) m_oreg[i][p] = m_lat[i][p];
        m_lat[i][p] = nl;
      end
      for (int p = 0; p < 2; p++) begin
        if (en[p] && we[p]) m_mem[i][ad[p]] = di[p];
      end
    end
    e = '0;
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        e[(i * 2 + p) * DW +: DW] = is_outreg(i, p) ? m_oreg[i][p] : m_lat[i][p];
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(int p);
    ce[p]  = 1'b0;
    we[p]  = 1'b0;
    oce[p] = 1'b1;
    rst[p] = 1'b0;
    cs[p]  = csd(p);
    ad[p]  = '0;
    di[p]  = '0;
  endtask

  task automatic set_port(int p, logic w, logic [2:0] c, int a, logic [DW-1:0] d);
    ce[p] = 1'b1;
    we[p] = w;
    cs[p] = c;
    ad[p] = AW'(a);
    di[p] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic check_const(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Pulse RSTN between edges (after the monitor has sampled), check outputs
  // clear at once, then release so the next edge is a normal one.
  task automatic async_reset();
    @(negedge clk);
    #1;
    idle(0);
    idle(1);
    rstn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check_const($sformatf("rstn_async_d%0d_doa", i), dut_do(i, 0), '0);
      check_const($sformatf("rstn_async_d%0d_dob", i), dut_do(i, 1), '0);
    end
    #1;
    rstn = 1'b1;
    tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [SB_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (dut_do(i, p) !== e[(i * 2 + p) * DW +: DW]) begin
              n_fail++;
              $display("FAIL sb_d%0d_do%s got=%h exp=%h at %0t", i, (p == 0) ? "a" : "b",
                       dut_do(i, p), e[(i * 2 + p) * DW +: DW], $time);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    idle(0);
    idle(1);
    model_reset();
    #2;
    for (int i = 0; i < NI; i++) begin
      check_const($sformatf("reset_d%0d_doa", i), dut_do(i, 0), '0);
      check_const($sformatf("reset_d%0d_dob", i), dut_do(i, 1), '0);
    end
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // Clear the working address range; RSTx keeps latches at 0 while writes still land.
    for (int a = 0; a < 16; a++) begin
      set_port(0, 1'b1, 3'b101, a, '0);
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      tick();
    end
    idle(0);
    idle(1);

    // Write A then read B, NOREG latency of one edge.
    set_port(0, 1'b1, 3'b101, 5, 18'h2A5A5);
    tick();
    idle(0);
    set_port(1, 1'b0, 3'b000, 5, '0);
    tick();
    check_const("noreg_read_b_d0", dob0, 18'h2A5A5);
    check_const("noreg_read_b_d2", dob2, 18'h2A5A5);
    idle(1);

    // OUTREG on d0 port A: two-edge latency, then OCEA = 0 holds.
    set_port(0, 1'b0, 3'b101, 5, '0);
    tick();
    idle(0);
    tick();
    check_const("outreg_2edge_d0", doa0, 18'h2A5A5);
    set_port(0, 1'b1, 3'b101, 6, 18'h12345);
    tick();
    set_port(0, 1'b0, 3'b101, 6, '0);
    tick();
    idle(0);
    oce[0] = 1'b0;
    tick();
    check_const("outreg_oce0_hold_d0", doa0, 18'h2A5A5);
    oce[0] = 1'b1;
    tick();
    check_const("outreg_oce1_load_d0", doa0, 18'h12345);

    // Write modes on port A.
    set_port(0, 1'b1, 3'b101, 7, 18'h00011);
    tick();
    set_port(0, 1'b0, 3'b101, 7, '0);
    tick();
    set_port(0, 1'b1, 3'b101, 7, 18'h00022);
    tick();
    check_const("wm_writethrough_d1", doa1, 18'h00022);
    check_const("wm_readbeforewrite_d2", doa2, 18'h00011);
    idle(0);
    tick();
    check_const("wm_normal_d0", doa0, 18'h00011);

    // Same-address collision: B wins.
    set_port(0, 1'b1, 3'b101, 3, 18'h00001);
    set_port(1, 1'b1, 3'b000, 3, 18'h00002);
    tick();
    idle(0);
    set_port(1, 1'b0, 3'b000, 3, '0);
    tick();
    check_const("collision_d0", dob0, 18'h00002);
    check_const("collision_d2", dob2, 18'h00002);
    idle(1);

    // Chip-select decode on port A.
    set_port(0, 1'b1, 3'b101, 9, 18'h00055);
    tick();
    set_port(0, 1'b1, 3'b100, 9, 18'h3FFFF);
    tick();
    set_port(0, 1'b0, 3'b101, 9, '0);
    tick();
    check_const("cs_mismatch_d2", doa2, 18'h00055);
    set_port(0, 1'b1, 3'b101, 9, 18'h3FFFF);
    tick();
    set_port(0, 1'b0, 3'b101, 9, '0);
    tick();
    check_const("cs_match_d2", doa2, 18'h3FFFF);
    idle(0);
    tick();

    // Asynchronous reset keeps memory; RSTB clears the read path.
    async_reset();
    set_port(0, 1'b0, 3'b101, 5, '0);
    set_port(1, 1'b0, 3'b000, 5, '0);
    tick();
    check_const("post_rstn_doa_d2", doa2, 18'h2A5A5);
    check_const("post_rstn_dob_d2", dob2, 18'h2A5A5);
    idle(0);
    rst[1] = 1'b1;
    tick();
    check_const("rstb_dob_d2", dob2, '0);
    check_const("rstb_doa_kept_d2", doa2, 18'h2A5A5);
    idle(1);

    // Randomised traffic over a small address window to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        ce[p]  = ($urandom_range(0, 3) != 0);
        we[p]  = 1'($urandom_range(0, 1));
        oce[p] = ($urandom_range(0, 3) != 0);
        rst[p] = ($urandom_range(0, 15) == 0);
        cs[p]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : csd(p);
        ad[p]  = AW'($urandom_range(0, 15));
        di[p]  = DW'($urandom);
      end
      tick();
      if (c == 300) async_reset();
    end
    idle(0);
    idle(1);

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
